// File: rtl/cpu_types_pkg.sv
// Shared types for the multicycle MIPS control path: FSM states, ALU ops,
// select encodings, instruction classes and opcode/funct constants.
package cpu_types_pkg;

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } ctrl_state_t;

    typedef enum logic [3:0] {
        ALU_SLL, ALU_SRL, ALU_ADD, ALU_SUB, ALU_AND,
        ALU_OR, ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU
    } aluop_t;

    typedef enum logic [1:0] {SRCB_RT = 2'd0, SRCB_SIMM = 2'd1, SRCB_ZIMM = 2'd2} srcb_sel_t;
    typedef enum logic [1:0] {REGDST_RD = 2'd0, REGDST_RT = 2'd1, REGDST_R31 = 2'd2} regdst_sel_t;
    typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_LUI = 2'd2, WB_PC4 = 2'd3} wb_sel_t;
    typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_BRANCH = 2'd1, PC_JUMP = 2'd2, PC_RS = 2'd3} pc_sel_t;

    typedef enum logic [3:0] {
        CLS_ALU, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE,
        CLS_J, CLS_JAL, CLS_JR, CLS_HALT, CLS_ILLEGAL
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_HALT  = 6'h3F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

endpackage

// File: rtl/control_decoder.sv
// Combinational decode of the latched instruction into ALU op, operand and
// writeback selects, an instruction class and an overflow-check flag.
module control_decoder
    import cpu_types_pkg::*;
(
    input  logic [31:0]  ir,
    output aluop_t       aluop,
    output logic         alu_srca_sel,
    output logic [1:0]   alu_srcb_sel,
    output logic [1:0]   regdst_sel,
    output logic [1:0]   wb_sel,
    output instr_class_t iclass,
    output logic         ovf_chk
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic       unused_ir;

    assign opcode    = ir[31:26];
    assign funct     = ir[5:0];
    assign unused_ir = ^ir[25:6];

    always_comb begin
        aluop        = ALU_ADD;
        alu_srca_sel = 1'b0;
        alu_srcb_sel = SRCB_RT;
        regdst_sel   = REGDST_RT;
        wb_sel       = WB_ALU;
        iclass       = CLS_ALU;
        ovf_chk      = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                regdst_sel = REGDST_RD;
                case (funct)
                    FN_SLL:  begin aluop = ALU_SLL; alu_srca_sel = 1'b1; end
                    FN_SRL:  begin aluop = ALU_SRL; alu_srca_sel = 1'b1; end
                    FN_JR:   iclass = CLS_JR;
                    FN_ADD:  begin aluop = ALU_ADD; ovf_chk = 1'b1; end
                    FN_ADDU: aluop = ALU_ADD;
                    FN_SUB:  begin aluop = ALU_SUB; ovf_chk = 1'b1; end
                    FN_SUBU: aluop = ALU_SUB;
                    FN_AND:  aluop = ALU_AND;
                    FN_OR:   aluop = ALU_OR;
                    FN_XOR:  aluop = ALU_XOR;
                    FN_NOR:  aluop = ALU_NOR;
                    FN_SLT:  aluop = ALU_SLT;
                    FN_SLTU: aluop = ALU_SLTU;
                    default: iclass = CLS_ILLEGAL;
                endcase
            end
            OP_ADDI:  begin aluop = ALU_ADD;  alu_srcb_sel = SRCB_SIMM; ovf_chk = 1'b1; end
            OP_ADDIU: begin aluop = ALU_ADD;  alu_srcb_sel = SRCB_SIMM; end
            OP_SLTI:  begin aluop = ALU_SLT;  alu_srcb_sel = SRCB_SIMM; end
            OP_SLTIU: begin aluop = ALU_SLTU; alu_srcb_sel = SRCB_SIMM; end
            OP_ANDI:  begin aluop = ALU_AND;  alu_srcb_sel = SRCB_ZIMM; end
            OP_ORI:   begin aluop = ALU_OR;   alu_srcb_sel = SRCB_ZIMM; end
            OP_XORI:  begin aluop = ALU_XOR;  alu_srcb_sel = SRCB_ZIMM; end
            OP_LUI:   begin alu_srcb_sel = SRCB_ZIMM; wb_sel = WB_LUI; end
            OP_LW: begin
                aluop = ALU_ADD; alu_srcb_sel = SRCB_SIMM; wb_sel = WB_MEM; iclass = CLS_LW;
            end
            OP_SW:    begin aluop = ALU_ADD; alu_srcb_sel = SRCB_SIMM; iclass = CLS_SW; end
            OP_BEQ:   begin aluop = ALU_SUB; iclass = CLS_BEQ; end
            OP_BNE:   begin aluop = ALU_SUB; iclass = CLS_BNE; end
            OP_J:     iclass = CLS_J;
            OP_JAL:   begin regdst_sel = REGDST_R31; wb_sel = WB_PC4; iclass = CLS_JAL; end
            OP_HALT:  iclass = CLS_HALT;
            default:  iclass = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer for the multicycle MIPS core with a
// FETCH/MEM watchdog. Define OVF_TRAP_EN to halt on signed add/sub/addi overflow.
module multicycle_control
    import cpu_types_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] iload,
    input  logic        ihit,
    input  logic        dhit,
    input  logic        zero,
    input  logic        negative,
    input  logic        overflow,
    output logic        iREN,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] ir,
    output aluop_t      aluop,
    output logic        alu_srca_sel,
    output logic [1:0]  alu_srcb_sel,
    output logic        regwen,
    output logic [1:0]  regdst_sel,
    output logic [1:0]  wb_sel,
    output logic        pc_en,
    output logic [1:0]  pc_sel,
    output logic        halt,
    output logic        fault,
    output logic        exc
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    ctrl_state_t  state_q, state_d;
    logic [31:0]  ir_q, ir_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic         halt_q, halt_d, fault_q, fault_d, exc_q, exc_d;
    logic         iren_c, dren_c, dwen_c, regwen_c, pc_en_c;
    logic [1:0]   pc_sel_c;
    instr_class_t iclass;
    logic         ovf_chk, trap, timeout;
    logic         unused_flags;

    control_decoder u_decoder (
        .ir           (ir_q),
        .aluop        (aluop),
        .alu_srca_sel (alu_srca_sel),
        .alu_srcb_sel (alu_srcb_sel),
        .regdst_sel   (regdst_sel),
        .wb_sel       (wb_sel),
        .iclass       (iclass),
        .ovf_chk      (ovf_chk)
    );

`ifdef OVF_TRAP_EN
    assign trap = ovf_chk & overflow;
`else
    logic unused_ovf;
    assign trap       = 1'b0;
    assign unused_ovf = ^{overflow, ovf_chk};
`endif

    assign unused_flags = negative;
    // Expiry is the TIMEOUT_CYCLES-th consecutive miss; a hit that same cycle wins.
    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        cnt_d    = '0;
        fault_d  = fault_q;
        exc_d    = exc_q;
        iren_c   = 1'b0;
        dren_c   = 1'b0;
        dwen_c   = 1'b0;
        regwen_c = 1'b0;
        pc_en_c  = 1'b0;
        pc_sel_c = PC_PLUS4;
        case (state_q)
            S_FETCH: begin
                iren_c = 1'b1;
                if (ihit) begin
                    ir_d    = iload;
                    state_d = S_DECODE;
                end else if (timeout) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DECODE: begin
                case (iclass)
                    CLS_HALT:    state_d = S_HALT;
                    CLS_ILLEGAL: begin state_d = S_HALT; fault_d = 1'b1; end
                    default:     state_d = S_EXEC;
                endcase
            end
            S_EXEC: begin
                if (trap) begin
                    state_d = S_HALT;
                    exc_d   = 1'b1;
                end else begin
                    case (iclass)
                        CLS_BEQ: begin
                            pc_en_c  = 1'b1;
                            pc_sel_c = zero ? PC_BRANCH : PC_PLUS4;
                            state_d  = S_FETCH;
                        end
                        CLS_BNE: begin
                            pc_en_c  = 1'b1;
                            pc_sel_c = zero ? PC_PLUS4 : PC_BRANCH;
                            state_d  = S_FETCH;
                        end
                        CLS_J: begin
                            pc_en_c  = 1'b1;
                            pc_sel_c = PC_JUMP;
                            state_d  = S_FETCH;
                        end
                        CLS_LW, CLS_SW: state_d = S_MEM;
                        default:        state_d = S_WB;
                    endcase
                end
            end
            S_MEM: begin
                dren_c = (iclass == CLS_LW);
                dwen_c = (iclass == CLS_SW);
                if (dhit) begin
                    pc_en_c = (iclass == CLS_SW);
                    state_d = (iclass == CLS_SW) ? S_FETCH : S_WB;
                end else if (timeout) begin
                    state_d = S_HALT;
                    fault_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                regwen_c = (iclass != CLS_JR);
                pc_en_c  = 1'b1;
                if (iclass == CLS_JAL)     pc_sel_c = PC_JUMP;
                else if (iclass == CLS_JR) pc_sel_c = PC_RS;
                state_d  = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
        halt_d = halt_q | (state_d == S_HALT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            cnt_q   <= '0;
            halt_q  <= 1'b0;
            fault_q <= 1'b0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            halt_q  <= halt_d;
            fault_q <= fault_d;
            exc_q   <= exc_d;
        end
    end

    // Reset masks every enable immediately so an aborted instruction leaves no side effect.
    assign iREN   = iren_c   & ~rst;
    assign dREN   = dren_c   & ~rst;
    assign dWEN   = dwen_c   & ~rst;
    assign regwen = regwen_c & ~rst;
    assign pc_en  = pc_en_c  & ~rst;
    assign pc_sel = pc_sel_c;
    assign ir     = ir_q;
    assign halt   = halt_q;
    assign fault  = fault_q;
    assign exc    = exc_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus random
// instructions checked against a per-instruction latency/select model.
module tb_multicycle_control;
    import cpu_types_pkg::*;

    localparam int TIMEOUT = 12;

    logic        clk, rst;
    logic [31:0] iload;
    logic        ihit, dhit, zero, negative, overflow;
    logic        iREN, dREN, dWEN;
    logic [31:0] ir;
    aluop_t      aluop;
    logic        alu_srca_sel;
    logic [1:0]  alu_srcb_sel, regdst_sel, wb_sel, pc_sel;
    logic        regwen, pc_en, halt, fault, exc;

    int tests_run = 0;
    int tests_failed = 0;

    int obs_cycles, obs_pcen, obs_pcsel, obs_iren, obs_dren, obs_dwen;
    int obs_regwen, obs_regdst, obs_wbsel, obs_srca, obs_srcb;
    aluop_t obs_aluop;

    typedef struct {
        int     cycles, iren, dren, dwen, regwen, regdst, wbsel, pcsel, srca, srcb;
        bit     chk_alu;
        aluop_t aluop;
    } exp_t;

    logic [11:0] legal [0:26];

    multicycle_control #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .iload(iload), .ihit(ihit), .dhit(dhit),
        .zero(zero), .negative(negative), .overflow(overflow),
        .iREN(iREN), .dREN(dREN), .dWEN(dWEN), .ir(ir), .aluop(aluop),
        .alu_srca_sel(alu_srca_sel), .alu_srcb_sel(alu_srcb_sel),
        .regwen(regwen), .regdst_sel(regdst_sel), .wb_sel(wb_sel),
        .pc_en(pc_en), .pc_sel(pc_sel), .halt(halt), .fault(fault), .exc(exc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Instruction-level reference: latency from the stage count, selects from the ISA table.
    function automatic exp_t predict(input logic [31:0] instr, input int iwait, input int dwait, input logic zero_v);
        exp_t e;
        logic [5:0] op, fn;
        op = instr[31:26];
        fn = instr[5:0];
        e.aluop = ALU_ADD; e.srca = 0; e.srcb = 0; e.chk_alu = 1'b1;
        e.regdst = 1; e.wbsel = 0; e.pcsel = 0; e.regwen = 1;
        e.dren = 0; e.dwen = 0; e.iren = iwait + 1;
        e.cycles = (iwait + 1) + 3;
        if (op == 6'h00) begin
            e.regdst = 0;
            case (fn)
                6'h00: begin e.aluop = ALU_SLL; e.srca = 1; end
                6'h02: begin e.aluop = ALU_SRL; e.srca = 1; end
                6'h08: begin e.chk_alu = 1'b0; e.regwen = 0; e.pcsel = 3; end
                6'h20, 6'h21: e.aluop = ALU_ADD;
                6'h22, 6'h23: e.aluop = ALU_SUB;
                6'h24: e.aluop = ALU_AND;
                6'h25: e.aluop = ALU_OR;
                6'h26: e.aluop = ALU_XOR;
                6'h27: e.aluop = ALU_NOR;
                6'h2A: e.aluop = ALU_SLT;
                default: e.aluop = ALU_SLTU;
            endcase
        end else begin
            case (op)
                6'h08, 6'h09: e.srcb = 1;
                6'h0A: begin e.aluop = ALU_SLT;  e.srcb = 1; end
                6'h0B: begin e.aluop = ALU_SLTU; e.srcb = 1; end
                6'h0C: begin e.aluop = ALU_AND;  e.srcb = 2; end
                6'h0D: begin e.aluop = ALU_OR;   e.srcb = 2; end
                6'h0E: begin e.aluop = ALU_XOR;  e.srcb = 2; end
                6'h0F: begin e.chk_alu = 1'b0; e.wbsel = 2; end
                6'h23: begin e.srcb = 1; e.wbsel = 1; e.dren = dwait + 1; e.cycles += dwait + 1; end
                6'h2B: begin e.srcb = 1; e.regwen = 0; e.dwen = dwait + 1; e.cycles += dwait; end
                6'h04: begin e.aluop = ALU_SUB; e.regwen = 0; e.cycles -= 1; e.pcsel = zero_v ? 1 : 0; end
                6'h05: begin e.aluop = ALU_SUB; e.regwen = 0; e.cycles -= 1; e.pcsel = zero_v ? 0 : 1; end
                6'h02: begin e.chk_alu = 1'b0; e.regwen = 0; e.cycles -= 1; e.pcsel = 2; end
                default: begin e.chk_alu = 1'b0; e.regdst = 2; e.wbsel = 3; e.pcsel = 2; end
            endcase
        end
        return e;
    endfunction

    // Runs one instruction cycle by cycle; must be entered at (or just after) a falling edge.
    task automatic applyStimulus(input logic [31:0] instr, input int iwait, input int dwait,
                                 input logic zero_v, input logic ovf_v, input int max_cyc);
        int  icnt, dcnt;
        bit  done;
        icnt = 0; dcnt = 0; done = 1'b0;
        obs_cycles = 0; obs_pcen = 0; obs_pcsel = -1; obs_iren = 0; obs_dren = 0; obs_dwen = 0;
        obs_regwen = 0; obs_regdst = -1; obs_wbsel = -1; obs_srca = -1; obs_srcb = -1;
        obs_aluop = ALU_SLTU;
        for (int c = 0; c < max_cyc && !done; c++) begin
            zero = zero_v; overflow = ovf_v; negative = 1'($urandom);
            ihit = 1'b0; dhit = 1'b0; iload = $urandom;
            #1;
            if (iREN) begin
                obs_iren++;
                if (icnt == iwait) begin ihit = 1'b1; iload = instr; end
                icnt++;
            end
            if (dREN || dWEN) begin
                obs_dren += int'(dREN);
                obs_dwen += int'(dWEN);
                if (dcnt == dwait) dhit = 1'b1;
                dcnt++;
            end
            #1;
            if (c == iwait + 2) begin
                obs_aluop = aluop; obs_srca = int'(alu_srca_sel); obs_srcb = int'(alu_srcb_sel);
            end
            if (regwen) begin
                obs_regwen++; obs_regdst = int'(regdst_sel); obs_wbsel = int'(wb_sel);
            end
            if (pc_en) begin
                obs_pcen++; obs_pcsel = int'(pc_sel); obs_cycles = c + 1; done = 1'b1;
            end
            @(negedge clk);
        end
        ihit = 1'b0; dhit = 1'b0;
    endtask

    task automatic checkInstr(input string name, input logic [31:0] instr, input int iwait,
                              input int dwait, input logic zero_v, input logic ovf_v);
        exp_t e;
        e = predict(instr, iwait, dwait, zero_v);
        applyStimulus(instr, iwait, dwait, zero_v, ovf_v, 40);
        checkOutput({name, " cycles"}, obs_cycles, e.cycles);
        checkOutput({name, " pc_en count"}, obs_pcen, 1);
        checkOutput({name, " pc_sel"}, obs_pcsel, e.pcsel);
        checkOutput({name, " iREN cycles"}, obs_iren, e.iren);
        checkOutput({name, " dREN cycles"}, obs_dren, e.dren);
        checkOutput({name, " dWEN cycles"}, obs_dwen, e.dwen);
        checkOutput({name, " regwen count"}, obs_regwen, e.regwen);
        checkOutput({name, " ir"}, ir, instr);
        if (e.regwen != 0) begin
            checkOutput({name, " regdst_sel"}, obs_regdst, e.regdst);
            checkOutput({name, " wb_sel"}, obs_wbsel, e.wbsel);
        end
        if (e.chk_alu) begin
            checkOutput({name, " aluop"}, obs_aluop, e.aluop);
            checkOutput({name, " srca"}, obs_srca, e.srca);
            checkOutput({name, " srcb"}, obs_srcb, e.srcb);
        end
    endtask

    task automatic doReset();
        rst = 1'b1; ihit = 1'b0; dhit = 1'b0; zero = 1'b0; overflow = 1'b0; negative = 1'b0; iload = '0;
        #1;
        checkOutput("rst iREN", iREN, 0);
        checkOutput("rst dREN", dREN, 0);
        checkOutput("rst dWEN", dWEN, 0);
        checkOutput("rst regwen", regwen, 0);
        checkOutput("rst pc_en", pc_en, 0);
        repeat (2) @(negedge clk);
        checkOutput("rst ir", ir, 0);
        checkOutput("rst halt", halt, 0);
        checkOutput("rst fault", fault, 0);
        checkOutput("rst exc", exc, 0);
        rst = 1'b0;
        #1 checkOutput("post-rst iREN", iREN, 1);
    endtask

    initial begin
        logic [11:0] kind;
        logic [31:0] rnd, instr;
        logic        ovf_v, is_trap;

        legal = '{12'h000, 12'h002, 12'h008, 12'h020, 12'h021, 12'h022, 12'h023, 12'h024, 12'h025,
                  12'h026, 12'h027, 12'h02A, 12'h02B, {6'h08, 6'h0}, {6'h09, 6'h0}, {6'h0A, 6'h0},
                  {6'h0B, 6'h0}, {6'h0C, 6'h0}, {6'h0D, 6'h0}, {6'h0E, 6'h0}, {6'h0F, 6'h0},
                  {6'h23, 6'h0}, {6'h2B, 6'h0}, {6'h04, 6'h0}, {6'h05, 6'h0}, {6'h02, 6'h0}, {6'h03, 6'h0}};

        doReset();
        checkInstr("add", 32'h00221820, 0, 0, 1'b0, 1'b0);
        checkInstr("lw_wait", 32'h8C220004, 0, 3, 1'b0, 1'b0);
        checkInstr("beq_taken", 32'h10220003, 0, 0, 1'b1, 1'b0);
        checkInstr("beq_not", 32'h10220003, 0, 0, 1'b0, 1'b0);
        checkInstr("bne_taken", 32'h14220003, 1, 0, 1'b0, 1'b0);
        checkInstr("sw", 32'hAC220004, 0, 0, 1'b0, 1'b0);
        checkInstr("j", 32'h08000010, 0, 0, 1'b0, 1'b0);
        checkInstr("jal", 32'h0C000010, 0, 0, 1'b0, 1'b0);
        checkInstr("jr", 32'h03E00008, 0, 0, 1'b0, 1'b0);
        checkInstr("lui", 32'h3C011234, 0, 0, 1'b0, 1'b0);
        checkInstr("sll", 32'h00021080, 2, 0, 1'b0, 1'b0);
        checkInstr("ori", 32'h3422FFFF, 0, 0, 1'b0, 1'b0);
        checkInstr("addu_ovf", 32'h00221821, 0, 0, 1'b0, 1'b1);
        checkInstr("late_ihit", 32'h00221820, TIMEOUT - 1, 0, 1'b0, 1'b0);
        checkInstr("late_dhit", 32'h8C220004, 0, TIMEOUT - 1, 1'b0, 1'b0);
        checkOutput("late hit fault", fault, 0);

`ifdef OVF_TRAP_EN
        applyStimulus(32'h00221820, 0, 0, 1'b0, 1'b1, 8);
        checkOutput("trap pc_en", obs_pcen, 0);
        checkOutput("trap regwen", obs_regwen, 0);
        checkOutput("trap halt", halt, 1);
        checkOutput("trap exc", exc, 1);
        doReset();
`else
        checkInstr("add_ovf", 32'h00221820, 0, 0, 1'b0, 1'b1);
        checkOutput("no-trap exc", exc, 0);
`endif

        for (int n = 0; n < 40; n++) begin
            kind = legal[$urandom_range(0, 26)];
            rnd  = $urandom;
            if (kind[11:6] == 6'h00) instr = {6'h00, rnd[25:6], kind[5:0]};
            else                     instr = {kind[11:6], rnd[25:0]};
            is_trap = (instr[31:26] == 6'h08) ||
                      (instr[31:26] == 6'h00 && (instr[5:0] == 6'h20 || instr[5:0] == 6'h22));
            ovf_v = is_trap ? 1'b0 : 1'($urandom);
            checkInstr($sformatf("rnd%0d", n), instr, $urandom_range(0, 2), $urandom_range(0, 3),
                       1'($urandom), ovf_v);
        end
        checkOutput("random halt", halt, 0);
        checkOutput("random fault", fault, 0);

        doReset();
        ihit = 1'b0;
        repeat (TIMEOUT - 1) @(negedge clk);
        #1;
        checkOutput("wd pre-expiry fault", fault, 0);
        checkOutput("wd pre-expiry iREN", iREN, 1);
        @(negedge clk);
        #1;
        checkOutput("wd fault", fault, 1);
        checkOutput("wd halt", halt, 1);
        checkOutput("wd iREN", iREN, 0);

        doReset();
        applyStimulus(32'hFC000000, 0, 0, 1'b0, 1'b0, 6);
        checkOutput("halt op halt", halt, 1);
        checkOutput("halt op fault", fault, 0);
        checkOutput("halt op pc_en", obs_pcen, 0);
        checkOutput("halt op iREN", obs_iren, 1);

        doReset();
        applyStimulus(32'hF8000000, 0, 0, 1'b0, 1'b0, 6);
        checkOutput("illegal fault", fault, 1);
        checkOutput("illegal halt", halt, 1);

        doReset();
        applyStimulus(32'h8C220004, 0, 6, 1'b0, 1'b0, 4);
        #1 checkOutput("mem dREN before rst", dREN, 1);
        checkOutput("mem dREN count", obs_dren, 1);
        doReset();
        checkInstr("after_abort", 32'h00221820, 0, 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
